// File: rtl/hpm_pkg.sv
// hpm_pkg: CSR space encodings and default sizing
// for the hardware performance counter bank.
package hpm_pkg;

  typedef enum logic [1:0] {
    SEL_CTR = 2'b00,
    SEL_EVT = 2'b01,
    SEL_INH = 2'b10,
    SEL_OVF = 2'b11
  } sel_e;

  localparam int DEF_NUM_CTR = 4;
  localparam int DEF_CTR_W   = 64;
  localparam int DEF_NUM_EVT = 16;

  function automatic int evt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpm_counter.sv
// hpm_counter: one performance counter with split
// 32-bit loads, increment and a wrap pulse.
module hpm_counter #(
  parameter int W = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ld_lo,
  input  logic         i_ld_hi,
  input  logic [31:0]  i_wdata,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_ld_lo) begin
      r_cnt[31:0] <= i_wdata;
    end else if (i_ld_hi) begin
      r_cnt[W-1:32] <= i_wdata[W-33:0];
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = i_inc & (&r_cnt);

endmodule

// File: rtl/hpm_counter_bank.sv
// hpm_counter_bank: event-selectable counter bank with CSR port.
// Overflow flags/interrupt built only with HPM_OVF_IRQ_EN.
module hpm_counter_bank
  import hpm_pkg::*;
#(
  parameter int NUM_CTR = DEF_NUM_CTR,
  parameter int CTR_W   = DEF_CTR_W,
  parameter int NUM_EVT = DEF_NUM_EVT
) (
  input  logic               proc_clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic [NUM_EVT-1:0] evt_vec,
  input  logic [1:0]         rd_sel,
  input  logic [4:0]         rd_idx,
  input  logic               rd_hi,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [1:0]         wr_sel,
  input  logic [4:0]         wr_idx,
  input  logic               wr_hi,
  input  logic [31:0]        wr_data,
  output logic               ovf_irq
);

  localparam int ES_W = evt_w(NUM_EVT);
  localparam int EP_W = 1 << ES_W;

  logic [CTR_W-1:0]   w_cnt [NUM_CTR];
  logic [ES_W-1:0]    r_evtsel [NUM_CTR];
  logic [NUM_CTR-1:0] r_inh;
  logic [NUM_CTR-1:0] w_inc;
  logic [NUM_CTR-1:0] w_wrap;
  logic [NUM_CTR-1:0] w_ld_lo;
  logic [NUM_CTR-1:0] w_ld_hi;
  logic [NUM_CTR-1:0] w_ovf;
  logic [EP_W-1:0]    w_evt_pad;
  logic [31:0]        w_rd;
  logic               w_wr_ctr;
  logic               w_wr_evt;
  logic               w_wr_inh;

  assign w_wr_ctr = wr_en && (wr_sel == SEL_CTR);
  assign w_wr_evt = wr_en && (wr_sel == SEL_EVT);
  assign w_wr_inh = wr_en && (wr_sel == SEL_INH);

  // Selectors past NUM_EVT land on zero padding.
  always_comb begin
    w_evt_pad = '0;
    w_evt_pad[NUM_EVT-1:0] = evt_vec;
  end

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    logic w_hit;
    assign w_hit = w_wr_ctr && (wr_idx == 5'(i));
    assign w_ld_lo[i] = w_hit && !wr_hi;
    assign w_ld_hi[i] = w_hit && wr_hi;
    assign w_inc[i] = w_evt_pad[r_evtsel[i]]
                   && !r_inh[i] && !freeze && !w_hit;

    hpm_counter #(.W(CTR_W)) u_ctr (
      .i_clk   (proc_clk),
      .i_rst   (rst),
      .i_ld_lo (w_ld_lo[i]),
      .i_ld_hi (w_ld_hi[i]),
      .i_wdata (wr_data),
      .i_inc   (w_inc[i]),
      .o_cnt   (w_cnt[i]),
      .o_wrap  (w_wrap[i])
    );
  end

  always_ff @(posedge proc_clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTR; i++)
        r_evtsel[i] <= ES_W'(i % NUM_EVT);
      r_inh <= '0;
    end else begin
      for (int i = 0; i < NUM_CTR; i++)
        if (w_wr_evt && (wr_idx == 5'(i)))
          r_evtsel[i] <= wr_data[ES_W-1:0];
      if (w_wr_inh)
        r_inh <= wr_data[NUM_CTR-1:0];
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_CTR-1:0] r_ovf;
  logic [NUM_CTR-1:0] w_clr;
  logic               r_irq;

  assign w_clr = (wr_en && (wr_sel == SEL_OVF))
               ? wr_data[NUM_CTR-1:0] : '0;

  // Set wins over a same-cycle clear.
  always_ff @(posedge proc_clk) begin
    if (rst) begin
      r_ovf <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~w_clr) | w_wrap;
      r_irq <= |r_ovf;
    end
  end

  assign w_ovf   = r_ovf;
  assign ovf_irq = r_irq;
`else
  assign w_ovf   = '0;
  assign ovf_irq = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    case (rd_sel)
      SEL_CTR: begin
        for (int i = 0; i < NUM_CTR; i++)
          if (rd_idx == 5'(i)) begin
            if (rd_hi)
              w_rd[CTR_W-33:0] = w_cnt[i][CTR_W-1:32];
            else
              w_rd = w_cnt[i][31:0];
          end
      end
      SEL_EVT: begin
        for (int i = 0; i < NUM_CTR; i++)
          if (rd_idx == 5'(i))
            w_rd[ES_W-1:0] = r_evtsel[i];
      end
      SEL_INH: w_rd[NUM_CTR-1:0] = r_inh;
      SEL_OVF: w_rd[NUM_CTR-1:0] = w_ovf;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge proc_clk) begin
    if (rst)
      rd_data <= '0;
    else if (!freeze)
      rd_data <= w_rd;
  end

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb_hpm_counter_bank: directed and random checks of the
// counter bank against a behavioural model.
module tb_hpm_counter_bank;
  import hpm_pkg::*;

  localparam int NC = 4;
  localparam int CW = 40;
  localparam int NE = 12;
  localparam int ESMOD = 1 << $clog2(NE);
  localparam logic [63:0] MASK = (64'd1 << CW) - 64'd1;
`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          proc_clk;
  logic          rst;
  logic          freeze;
  logic [NE-1:0] evt_vec;
  logic [1:0]    rd_sel;
  logic [4:0]    rd_idx;
  logic          rd_hi;
  logic [31:0]   rd_data;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [4:0]    wr_idx;
  logic          wr_hi;
  logic [31:0]   wr_data;
  logic          ovf_irq;

  int nchk = 0;
  int nerr = 0;

  hpm_counter_bank #(
    .NUM_CTR (NC),
    .CTR_W   (CW),
    .NUM_EVT (NE)
  ) dut (
    .proc_clk (proc_clk),
    .rst      (rst),
    .freeze   (freeze),
    .evt_vec  (evt_vec),
    .rd_sel   (rd_sel),
    .rd_idx   (rd_idx),
    .rd_hi    (rd_hi),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_idx   (wr_idx),
    .wr_hi    (wr_hi),
    .wr_data  (wr_data),
    .ovf_irq  (ovf_irq)
  );

  initial proc_clk = 1'b0;
  always #5 proc_clk = ~proc_clk;

  logic [63:0]   m_cnt [NC];
  int            m_evt [NC];
  logic [NC-1:0] m_inh;
  logic [NC-1:0] m_ovf;
  logic          m_irq;
  logic [31:0]   m_rd;
  bit            m_valid = 1'b0;

  function automatic logic [31:0] model_read(
    input logic [1:0] s, input int idx, input logic hi);
    logic [31:0] v;
    v = '0;
    if (s == SEL_CTR && idx < NC)
      v = hi ? 32'(m_cnt[idx] >> 32) : m_cnt[idx][31:0];
    else if (s == SEL_EVT && idx < NC)
      v = 32'(m_evt[idx]);
    else if (s == SEL_INH)
      v = 32'(m_inh);
    else if (s == SEL_OVF && OVF_EN)
      v = 32'(m_ovf);
    return v;
  endfunction

  always @(posedge proc_clk) begin : model_b
    logic [NC-1:0] set;
    logic [31:0]   nrd;
    logic          nirq;
    int            widx;
    bit            hit;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_cnt[i] = '0;
        m_evt[i] = i % NE;
      end
      m_inh = '0;
      m_ovf = '0;
      m_irq = 1'b0;
      m_rd = '0;
      m_valid = 1'b1;
    end else begin
      nrd = freeze ? m_rd
                   : model_read(rd_sel, int'(rd_idx), rd_hi);
      nirq = OVF_EN && (m_ovf != '0);
      set = '0;
      widx = int'(wr_idx);
      for (int i = 0; i < NC; i++) begin
        hit = wr_en && wr_sel == SEL_CTR && widx == i;
        if (hit) begin
          if (wr_hi)
            m_cnt[i] = ((64'(wr_data) << 32)
                     | (m_cnt[i] & 64'hFFFF_FFFF)) & MASK;
          else
            m_cnt[i] = (m_cnt[i] & ~64'hFFFF_FFFF)
                     | 64'(wr_data);
        end else if (!freeze && !m_inh[i] && m_evt[i] < NE
                     && evt_vec[m_evt[i]]) begin
          m_cnt[i] = (m_cnt[i] + 64'd1) & MASK;
          if (m_cnt[i] == '0) set[i] = 1'b1;
        end
      end
      if (wr_en && wr_sel == SEL_EVT && widx < NC)
        m_evt[widx] = int'(wr_data % ESMOD);
      if (wr_en && wr_sel == SEL_INH)
        m_inh = wr_data[NC-1:0];
      if (OVF_EN) begin
        if (wr_en && wr_sel == SEL_OVF)
          m_ovf = m_ovf & ~wr_data[NC-1:0];
        m_ovf = m_ovf | set;
      end
      m_rd = nrd;
      m_irq = nirq;
    end
  end

  always @(negedge proc_clk) begin
    if (m_valid) begin
      nchk++;
      if (rd_data !== m_rd) begin
        nerr++;
        $display("FAIL model_rd t=%0t: got %h expected %h",
                 $time, rd_data, m_rd);
      end
      nchk++;
      if (ovf_irq !== m_irq) begin
        nerr++;
        $display("FAIL model_irq t=%0t: got %b expected %b",
                 $time, ovf_irq, m_irq);
      end
    end
  end

  task automatic cyc();
    @(negedge proc_clk);
  endtask

  task automatic idle_in();
    rst = 1'b0;
    freeze = 1'b0;
    evt_vec = '0;
    wr_en = 1'b0;
    wr_sel = 2'b00;
    wr_idx = '0;
    wr_hi = 1'b0;
    wr_data = '0;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] s, input logic [4:0] idx,
                    input logic hi, input logic [31:0] d);
    idle_in();
    wr_en = 1'b1;
    wr_sel = s;
    wr_idx = idx;
    wr_hi = hi;
    wr_data = d;
    cyc();
    idle_in();
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] s,
                        input logic [4:0] idx, input logic hi,
                        input logic [31:0] exp);
    idle_in();
    rd_sel = s;
    rd_idx = idx;
    rd_hi = hi;
    cyc();
    chk(nm, rd_data, exp);
    chk({nm, "_model"}, m_rd, exp);
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    rd_sel = 2'b00;
    rd_idx = '0;
    rd_hi = 1'b0;
    cyc();
    cyc();
    idle_in();
    chk("rst_rd", rd_data, 32'h0);
    chk("rst_irq", 32'(ovf_irq), 32'h0);

    rd_chk("evtsel2", SEL_EVT, 5'd2, 1'b0, 32'd2);
    rd_chk("ctr1_lo0", SEL_CTR, 5'd1, 1'b0, 32'd0);
    rd_chk("ctr3_hi0", SEL_CTR, 5'd3, 1'b1, 32'd0);

    wr(SEL_EVT, 5'd0, 1'b0, 32'd3);
    for (int k = 0; k < 10; k++) begin
      idle_in();
      evt_vec = 12'h008;
      freeze = (k == 3 || k == 6);
      cyc();
    end
    rd_chk("ctr0_frz", SEL_CTR, 5'd0, 1'b0, 32'd8);
    rd_chk("ctr3_frz", SEL_CTR, 5'd3, 1'b0, 32'd8);

    wr(SEL_CTR, 5'd1, 1'b0, 32'hFFFF_FFFF);
    wr(SEL_CTR, 5'd1, 1'b1, 32'h0);
    evt_vec = 12'h002;
    cyc();
    rd_chk("carry_lo", SEL_CTR, 5'd1, 1'b0, 32'h0);
    rd_chk("carry_hi", SEL_CTR, 5'd1, 1'b1, 32'h1);

    rd_sel = SEL_CTR;
    rd_idx = 5'd1;
    rd_hi = 1'b0;
    wr_en = 1'b1;
    wr_sel = SEL_CTR;
    wr_idx = 5'd1;
    wr_data = 32'h77;
    cyc();
    chk("rd_prewrite", rd_data, 32'h0);
    rd_chk("rd_postwrite", SEL_CTR, 5'd1, 1'b0, 32'h77);

    evt_vec = 12'h008;
    wr_en = 1'b1;
    wr_sel = SEL_CTR;
    wr_idx = 5'd0;
    wr_data = 32'h1234;
    cyc();
    rd_chk("wr_prio", SEL_CTR, 5'd0, 1'b0, 32'h1234);
    wr(SEL_INH, 5'd0, 1'b0, 32'h1);
    for (int k = 0; k < 5; k++) begin
      evt_vec = 12'hFFF;
      cyc();
    end
    rd_chk("inh_ctr0", SEL_CTR, 5'd0, 1'b0, 32'h1234);
    rd_chk("inh_ctr1", SEL_CTR, 5'd1, 1'b0, 32'h7C);
    rd_chk("inh_ctr2", SEL_CTR, 5'd2, 1'b0, 32'h5);
    rd_chk("inh_rd", SEL_INH, 5'd0, 1'b0, 32'h1);

    wr(SEL_INH, 5'd0, 1'b0, 32'h0);
    wr(SEL_CTR, 5'd3, 1'b0, 32'hFFFF_FFFF);
    wr(SEL_CTR, 5'd3, 1'b1, 32'hFF);
    evt_vec = 12'h008;
    cyc();
    idle_in();
    chk("irq_pre", 32'(ovf_irq), 32'h0);
    cyc();
    chk("irq_set", 32'(ovf_irq), OVF_EN ? 32'h1 : 32'h0);
    rd_chk("wrap_lo", SEL_CTR, 5'd3, 1'b0, 32'h0);
    rd_chk("wrap_hi", SEL_CTR, 5'd3, 1'b1, 32'h0);
    rd_chk("ovf_rd", SEL_OVF, 5'd0, 1'b0,
           OVF_EN ? 32'h8 : 32'h0);
    wr(SEL_OVF, 5'd0, 1'b0, 32'h8);
    chk("irq_hold", 32'(ovf_irq), OVF_EN ? 32'h1 : 32'h0);
    cyc();
    chk("irq_clr", 32'(ovf_irq), 32'h0);

    wr(SEL_CTR, 5'd7, 1'b0, 32'hDEAD);
    wr(SEL_EVT, 5'd7, 1'b0, 32'h5);
    rd_chk("ctr7", SEL_CTR, 5'd7, 1'b0, 32'h0);
    rd_chk("evt7", SEL_EVT, 5'd7, 1'b0, 32'h0);
    rd_chk("ctr0_keep", SEL_CTR, 5'd0, 1'b0, 32'h1235);
    rd_chk("evt3_keep", SEL_EVT, 5'd3, 1'b0, 32'h3);

    wr(SEL_EVT, 5'd2, 1'b0, 32'hFD);
    rd_chk("evt2_trunc", SEL_EVT, 5'd2, 1'b0, 32'd13);
    for (int k = 0; k < 3; k++) begin
      evt_vec = 12'hFFF;
      cyc();
    end
    rd_chk("evt_oob", SEL_CTR, 5'd2, 1'b0, 32'h5);

    idle_in();
    freeze = 1'b1;
    rd_sel = SEL_EVT;
    cyc();
    chk("frz_hold", rd_data, 32'h5);

    rst = 1'b1;
    freeze = 1'b1;
    wr_en = 1'b1;
    wr_sel = SEL_CTR;
    wr_idx = 5'd0;
    wr_data = 32'hABCD;
    evt_vec = 12'hFFF;
    cyc();
    idle_in();
    chk("rst_ovr", rd_data, 32'h0);
    rd_chk("rst_ctr0", SEL_CTR, 5'd0, 1'b0, 32'h0);
    rd_chk("rst_evt0", SEL_EVT, 5'd0, 1'b0, 32'h0);

    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      evt_vec = NE'($urandom);
      wr_en = ($urandom_range(0, 3) == 0);
      wr_sel = 2'($urandom);
      wr_idx = 5'($urandom_range(0, 7));
      wr_hi = 1'($urandom);
      wr_data = ($urandom_range(0, 2) == 0)
              ? 32'hFFFF_FFFF : $urandom;
      rd_sel = 2'($urandom);
      rd_idx = 5'($urandom_range(0, 7));
      rd_hi = 1'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/hpm_counter_bank.md
HPM_COUNTER_BANK -- requirements
Module: hpm_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CTR, default 4, meaning the number of counters (1..32).
REQ-002 SHALL have parameter CTR_W, default 64, meaning the counter width (33..64).
REQ-003 SHALL have parameter NUM_EVT, default 16, meaning the number of event inputs (2..64).
REQ-004 SHALL have port proc_clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port freeze, input, 1 bit: pipeline stall; pauses counting and holds rd_data.
REQ-007 SHALL have port evt_vec, input, NUM_EVT bits: per-cycle event pulses.
REQ-008 SHALL have port rd_sel, input, 2 bits: read space (00 counter, 01 evtsel, 10 inhibit, 11 ovf status).
REQ-009 SHALL have port rd_idx, input, 5 bits: counter index for spaces 00 and 01.
REQ-010 SHALL have port rd_hi, input, 1 bit: select counter bits [CTR_W-1:32] when high.
REQ-011 SHALL have port rd_data, output, 32 bits: registered read data.
REQ-012 SHALL have ports wr_en (1 bit), wr_sel (2 bits), wr_idx (5 bits), wr_hi (1 bit) and wr_data (32 bits), all inputs, forming the CSR write port with the same encoding as the read port.
REQ-013 SHALL have port ovf_irq, output, 1 bit: overflow interrupt request.

Function
REQ-014 Counter i SHALL increment by 1 in a cycle when evt_vec[evtsel[i]] is 1, inhibit[i] is 0, freeze is 0, and no write targets counter i.
REQ-015 An evtsel[i] value of NUM_EVT or higher SHALL never increment counter i.
REQ-016 Counters SHALL wrap from all-ones (CTR_W bits) to 0.
REQ-017 A counter write SHALL take effect on the next edge: wr_hi=0 replaces bits [31:0], wr_hi=1 replaces bits [CTR_W-1:32] using wr_data[CTR_W-33:0]; the other half is unchanged.
REQ-018 A write SHALL take priority over a same-cycle increment; that event is dropped.
REQ-019 Writes SHALL take effect regardless of freeze.
REQ-020 An evtsel write SHALL store wr_data[$clog2(NUM_EVT)-1:0] (minimum width 1).
REQ-021 An inhibit write SHALL store wr_data[NUM_CTR-1:0].
REQ-022 An index at or above NUM_CTR SHALL be ignored on write and SHALL read as 0.
REQ-023 rd_data SHALL update one cycle after the rd_* inputs when freeze=0, and SHALL hold its value when freeze=1.
REQ-024 The high-half read SHALL be zero-extended; unused bits in the evtsel and inhibit reads SHALL read 0.
REQ-025 A same-cycle read of a location being written SHALL return the pre-write value.

Reset
REQ-026 On rst=1 at a proc_clk edge: all counters, inhibit, ovf status, rd_data and ovf_irq SHALL become 0.
REQ-027 On rst=1 at a proc_clk edge: evtsel[i] SHALL become i mod NUM_EVT.
REQ-028 rst SHALL override freeze and wr_en; an rst asserted mid-operation SHALL discard pending events.

Configuration
REQ-029 With macro HPM_OVF_IRQ_EN defined, a wrap of counter i caused by an increment SHALL set sticky ovf[i].
REQ-030 With HPM_OVF_IRQ_EN defined, a write with wr_sel=11 SHALL clear each ovf bit whose wr_data bit is 1; a set and a clear on the same bit in the same cycle SHALL leave it set.
REQ-031 With HPM_OVF_IRQ_EN defined, ovf_irq SHALL be registered as OR(ovf), i.e. 1 cycle after the flag is set.
REQ-032 Without HPM_OVF_IRQ_EN, the ovf logic SHALL be absent, space 11 SHALL read 0, writes to it SHALL be ignored, and ovf_irq SHALL be tied to 0.

Structure
REQ-033 Package hpm_pkg SHALL hold the rd_sel/wr_sel space constants (SEL_CTR, SEL_EVT, SEL_INH, SEL_OVF) and the default parameter values.
REQ-034 Sub-module hpm_counter SHALL implement one counter (load-lo, load-hi, increment, wrap pulse), instantiated NUM_CTR times.

Verification
REQ-035 Reset, then events idle; read counter 2 evtsel -> rd_data=2; read any counter -> 0.
REQ-036 evtsel[0]=3, pulse evt_vec[3] for 10 cycles with 2 of them under freeze -> counter 0 reads 8.
REQ-037 Write counter 1 lo=0xFFFFFFFF and hi=0x0, then 1 event -> lo=0x0, hi=0x1 (carry across halves).
REQ-038 Write counter 0 in the same cycle its event fires -> counter 0 reads exactly wr_data; inhibit=0x1 -> counter 0 frozen while counter 1 still counts.
REQ-039 With HPM_OVF_IRQ_EN defined and CTR_W=40: set counter 3 to 0xFF_FFFFFFFF, then 1 event -> counter 3 = 0, ovf=0x8, ovf_irq=1 one cycle later; write 0x8 to ovf -> ovf_irq=0 after 2 cycles.
REQ-040 wr_idx=7 with NUM_CTR=4 -> no state change, and a read of index 7 returns 0.
